// File: rtl/wide_sub_sequencer_if.sv
// Valid/ready operand and result bundle for the wide subtraction sequencer.
interface wide_sub_sequencer_if #(
  parameter int unsigned W = 120
);
  logic         io_in_valid;
  logic         io_in_ready;
  logic [W-1:0] io_in_a;
  logic [W-1:0] io_in_b;
  logic         io_out_valid;
  logic         io_out_ready;
  logic [W-1:0] io_out_diff;
  logic         io_out_borrow;

  modport master (
    output io_in_valid, io_in_a, io_in_b, io_out_ready,
    input  io_in_ready, io_out_valid, io_out_diff, io_out_borrow
  );

  modport slave (
    input  io_in_valid, io_in_a, io_in_b, io_out_ready,
    output io_in_ready, io_out_valid, io_out_diff, io_out_borrow
  );
endinterface

// File: rtl/wide_sub_sequencer.sv
// Wide unsigned subtractor: one shared 15-bit subtractor stepped over the limbs,
// LSB limb first, with the ripple borrow kept in the controller.
module full_subtractor (
  input  logic [14:0] io_in_a,
  input  logic [14:0] io_in_b,
  output logic [14:0] s1,
  output logic        c1
);
  assign {c1, s1} = {1'b0, io_in_a} - {1'b0, io_in_b};
endmodule

module wide_sub_sequencer #(
  parameter int unsigned LIMB_W    = 15,
  parameter int unsigned NUM_LIMBS = 8,
  parameter int unsigned IDX_W     = 3
) (
  input logic                  clock,
  input logic                  reset,
  wide_sub_sequencer_if.slave  io
);
  localparam int unsigned W = NUM_LIMBS * LIMB_W;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   limb_idx;
  logic               borrow;
  logic [W-1:0]       a_reg, b_reg, diff_reg;
  logic [LIMB_W-1:0]  a_limb, b_limb, s1, limb_diff;
  logic               c1, borrow_d, last_limb;

  assign a_limb    = a_reg[limb_idx*LIMB_W +: LIMB_W];
  assign b_limb    = b_reg[limb_idx*LIMB_W +: LIMB_W];
  assign last_limb = (limb_idx == IDX_W'(NUM_LIMBS - 1));

  full_subtractor u_sub (
    .io_in_a (a_limb),
    .io_in_b (b_limb),
    .s1      (s1),
    .c1      (c1)
  );

  // The subtractor has no borrow-in, so the incoming borrow is folded in here;
  // it can only propagate further when s1 was zero.
  assign limb_diff = s1 - {{(LIMB_W-1){1'b0}}, borrow};
  assign borrow_d  = c1 | (borrow & (s1 == '0));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d          = state;
    io.io_in_ready   = 1'b0;
    io.io_out_valid  = 1'b0;
    io.io_out_diff   = diff_reg;
    io.io_out_borrow = borrow;
    case (state)
      IDLE: begin
        io.io_in_ready = 1'b1;
        if (io.io_in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_limb) state_d = DONE;
      end
      DONE: begin
        io.io_out_valid = 1'b1;
        if (io.io_out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      limb_idx <= '0;
      borrow   <= 1'b0;
      diff_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.io_in_valid) begin
            a_reg    <= io.io_in_a;
            b_reg    <= io.io_in_b;
            limb_idx <= '0;
            borrow   <= 1'b0;
          end
        end
        RUN: begin
          diff_reg[limb_idx*LIMB_W +: LIMB_W] <= limb_diff;
          borrow   <= borrow_d;
          limb_idx <= last_limb ? '0 : limb_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wide_sub_sequencer.sv
// Self-checking bench: arithmetic/timing reference model plus directed literal checks.
module tb_wide_sub_sequencer;
  localparam int unsigned W = 120;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  wide_sub_sequencer_if #(.W(W)) bus ();

  wide_sub_sequencer #(.LIMB_W(15), .NUM_LIMBS(8), .IDX_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: result is (a-b) mod 2^W, borrow is a<b; result shows up
  // 9 cycles after accept and stays until the out handshake.
  logic         m_init = 1'b0;
  logic         m_busy = 1'b0;
  logic         m_zero = 1'b1;
  int           m_cnt  = 0;
  logic [W-1:0] m_diff = '0;
  logic         m_borrow = 1'b0;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_init = 1'b1;
      m_busy = 1'b0;
      m_cnt  = 0;
      m_zero = 1'b1;
    end else if (!m_busy) begin
      if (bus.io_in_valid) begin
        m_busy   = 1'b1;
        m_cnt    = 1;
        m_zero   = 1'b0;
        m_diff   = bus.io_in_a - bus.io_in_b;
        m_borrow = (bus.io_in_a < bus.io_in_b);
      end
    end else if (m_cnt >= 9 && bus.io_out_ready) begin
      m_busy = 1'b0;
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clock) begin
    if (m_init) begin
      check("in_ready", {120'b0, bus.io_in_ready}, {120'b0, !m_busy});
      check("out_valid", {120'b0, bus.io_out_valid}, {120'b0, (m_busy && m_cnt >= 9)});
      if (m_busy && m_cnt >= 9) begin
        check("out_diff", {1'b0, bus.io_out_diff}, {1'b0, m_diff});
        check("out_borrow", {120'b0, bus.io_out_borrow}, {120'b0, m_borrow});
      end
      if (m_zero) begin
        check("diff_after_reset", {1'b0, bus.io_out_diff}, '0);
        check("borrow_after_reset", {120'b0, bus.io_out_borrow}, '0);
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.io_in_valid = v;
    bus.io_in_a     = a;
    bus.io_in_b     = b;
  endtask

  // Called at the first falling edge after the accepting rising edge.
  task automatic wait_result(input string name, input logic [W-1:0] exp_d, input logic exp_b);
    int lat = 1;
    while (!bus.io_out_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    check({name, "_latency"}, lat, 9);
    check({name, "_diff"}, {1'b0, bus.io_out_diff}, {1'b0, exp_d});
    check({name, "_borrow"}, {120'b0, bus.io_out_borrow}, {120'b0, exp_b});
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_b);
    @(negedge clock);
    check({name, "_ready"}, {120'b0, bus.io_in_ready}, 1);
    drive(1'b1, a, b);
    bus.io_out_ready = 1'b1;
    @(negedge clock);
    drive(1'b0, '0, '0);
    wait_result(name, exp_d, exp_b);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  logic [W-1:0] pa [3];
  logic [W-1:0] pb [3];
  logic [W-1:0] pd [3];
  logic         pbr[3];
  int           acc_cyc[3];
  int           n_acc, n_res;
  logic         took;

  initial begin
    drive(1'b0, '0, '0);
    bus.io_out_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_in_ready", {120'b0, bus.io_in_ready}, 1);
    check("rst_out_valid", {120'b0, bus.io_out_valid}, 0);
    check("rst_diff", {1'b0, bus.io_out_diff}, 0);

    run_op("t1", 120'd5, 120'd3, 120'd2, 1'b0);
    run_op("t2", 120'h8000, 120'd1, 120'h7FFF, 1'b0);
    run_op("t3", 120'd0, 120'd1, {W{1'b1}}, 1'b1);

    // Consumer stalls; new operands offered during DONE must be ignored.
    @(negedge clock);
    drive(1'b1, 120'd5, 120'd3);
    bus.io_out_ready = 1'b0;
    @(negedge clock);
    drive(1'b0, '0, '0);
    wait_result("t4a", 120'd2, 1'b0);
    drive(1'b1, 120'd77, 120'd7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t4_hold_valid", {120'b0, bus.io_out_valid}, 1);
      check("t4_hold_diff", {1'b0, bus.io_out_diff}, 2);
      check("t4_hold_ready", {120'b0, bus.io_in_ready}, 0);
    end
    bus.io_out_ready = 1'b1;
    @(negedge clock);
    check("t4_idle_ready", {120'b0, bus.io_in_ready}, 1);
    @(negedge clock);
    drive(1'b0, '0, '0);
    wait_result("t4b", 120'd70, 1'b0);

    // Reset during the limb-3 RUN cycle.
    @(negedge clock);
    drive(1'b1, {W{1'b1}}, 120'd1);
    @(negedge clock);
    drive(1'b0, '0, '0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t5_ready", {120'b0, bus.io_in_ready}, 1);
    check("t5_valid", {120'b0, bus.io_out_valid}, 0);
    check("t5_diff", {1'b0, bus.io_out_diff}, 0);
    check("t5_borrow", {120'b0, bus.io_out_borrow}, 0);
    run_op("t5eq", 120'd10, 120'd10, 120'd0, 1'b0);

    // Back-to-back issue with in_valid held high.
    pa[0] = 120'd100;            pb[0] = 120'd1; pd[0] = 120'd99;          pbr[0] = 1'b0;
    pa[1] = 120'd1;              pb[1] = 120'd2; pd[1] = {W{1'b1}};        pbr[1] = 1'b1;
    pa[2] = 120'h1_0000_0000;    pb[2] = 120'd1; pd[2] = 120'hFFFF_FFFF;   pbr[2] = 1'b0;
    n_acc = 0;
    n_res = 0;
    @(negedge clock);
    drive(1'b1, pa[0], pb[0]);
    bus.io_out_ready = 1'b1;
    for (int k = 0; k < 60 && n_res < 3; k++) begin
      took = 1'b0;
      if (bus.io_out_valid) begin
        check("t6_diff", {1'b0, bus.io_out_diff}, {1'b0, pd[n_res]});
        check("t6_borrow", {120'b0, bus.io_out_borrow}, {120'b0, pbr[n_res]});
        n_res++;
      end
      if (bus.io_in_ready && bus.io_in_valid && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        took = 1'b1;
      end
      @(negedge clock);
      if (took) begin
        if (n_acc < 3) drive(1'b1, pa[n_acc], pb[n_acc]);
        else           drive(1'b0, '0, '0);
      end
    end
    check("t6_accepts", n_acc, 3);
    check("t6_results", n_res, 3);
    if (n_acc == 3) begin
      check("t6_gap01", acc_cyc[1] - acc_cyc[0], 10);
      check("t6_gap12", acc_cyc[2] - acc_cyc[1], 10);
    end

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
